// File: rtl/pool_ctrl.sv
// Sequencer for 2x2 max-pooling over one SRAM-resident feature map: issues window
// reads in 6-cycle frames, captures the pooled result and writes it to the output map.
module pool_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  in_width,
  input  logic [DIM_W-1:0]  in_height,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  output logic              ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic              pool_en,
  input  logic [DATA_W-1:0] pool_result,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic [DATA_W-1:0] ofm_wdata
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] wid, row_ptr, col_off, out_ptr;
  logic [DIM_W-1:0]  ow, oh, c_cnt, r_cnt;
  logic [2:0]        phase, np;
  logic              col_last, win_last;
  logic [ADDR_W-1:0] nxt_row, nxt_col, rd_addr;

  // row_ptr tracks in_base + 2r*W and col_off tracks 2c, so no multiplier is needed
  always_comb begin
    col_last = (c_cnt == ow - ONE_D);
    win_last = col_last && (r_cnt == oh - ONE_D);
    np       = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    nxt_row  = col_last ? row_ptr + {wid[ADDR_W-2:0], 1'b0} : row_ptr;
    nxt_col  = col_last ? '0 : col_off + ADDR_W'(2);
    if (phase == 3'd5)
      rd_addr = nxt_row + nxt_col;
    else
      rd_addr = row_ptr + col_off + (np[1] ? wid : '0) + ADDR_W'(np[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wid       <= '0;
      row_ptr   <= '0;
      col_off   <= '0;
      out_ptr   <= '0;
      ow        <= '0;
      oh        <= '0;
      c_cnt     <= '0;
      r_cnt     <= '0;
      phase     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ifm_rd_en <= 1'b0;
      ifm_addr  <= '0;
      pool_en   <= 1'b0;
      ofm_wr_en <= 1'b0;
      ofm_addr  <= '0;
      ofm_wdata <= '0;
    end else begin
      ofm_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          wid     <= ADDR_W'(in_width);
          ow      <= in_width >> 1;
          oh      <= in_height >> 1;
          c_cnt   <= '0;
          r_cnt   <= '0;
          row_ptr <= in_base;
          col_off <= '0;
          out_ptr <= out_base;
          phase   <= '0;
          busy    <= 1'b1;
          // degenerate maps skip RUN entirely; FLUSH then carries no write
          if (in_width[DIM_W-1:1] == '0 || in_height[DIM_W-1:1] == '0) begin
            state <= FLUSH;
          end else begin
            state     <= RUN;
            pool_en   <= 1'b1;
            ifm_rd_en <= 1'b1;
            ifm_addr  <= in_base;
          end
        end
        RUN: begin
          if (phase == 3'd5) begin
            ofm_wdata <= pool_result;
            ofm_wr_en <= 1'b1;
            ofm_addr  <= out_ptr;
            out_ptr   <= out_ptr + ADDR_W'(1);
            phase     <= '0;
            if (win_last) begin
              state     <= FLUSH;
              pool_en   <= 1'b0;
              ifm_rd_en <= 1'b0;
            end else begin
              c_cnt     <= col_last ? '0 : c_cnt + ONE_D;
              r_cnt     <= col_last ? r_cnt + ONE_D : r_cnt;
              row_ptr   <= nxt_row;
              col_off   <= nxt_col;
              ifm_rd_en <= 1'b1;
              ifm_addr  <= rd_addr;
            end
          end else begin
            phase     <= np;
            ifm_rd_en <= (phase < 3'd3);
            if (phase < 3'd3) ifm_addr <= rd_addr;
          end
        end
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_ctrl.sv
// Randomized self-checking bench for pool_ctrl: SRAM plus pooling-unit stand-in,
// windows/addresses predicted arithmetically from the map geometry.
module tb_pool_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, ifm_rd_en, pool_en, ofm_wr_en;
  logic [7:0]  in_width, in_height;
  logic [15:0] in_base, out_base, ifm_addr, ofm_addr;
  logic [31:0] pool_result, ofm_wdata;

  pool_ctrl #(.DATA_W(32), .ADDR_W(16), .DIM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_width(in_width), .in_height(in_height),
    .in_base(in_base), .out_base(out_base), .busy(busy), .done(done),
    .ifm_rd_en(ifm_rd_en), .ifm_addr(ifm_addr), .pool_en(pool_en),
    .pool_result(pool_result), .ofm_wr_en(ofm_wr_en), .ofm_addr(ofm_addr),
    .ofm_wdata(ofm_wdata)
  );

  always #5 clk = ~clk;

  // input SRAM (1-cycle read) and a pooling unit with its own free-running frame counter
  logic [31:0] mem [0:65535];
  logic [31:0] rdata, acc;
  logic [2:0]  pcnt;
  always @(posedge clk) begin
    if (ifm_rd_en) rdata <= mem[ifm_addr];
    if (!pool_en) pcnt <= 3'd0;
    else pcnt <= (pcnt == 3'd5) ? 3'd0 : pcnt + 3'd1;
    if (pool_en) begin
      if (pcnt == 3'd1) acc <= rdata;
      else if (pcnt >= 3'd2 && pcnt <= 3'd4 && rdata > acc) acc <= rdata;
    end
  end
  assign pool_result = acc;

  int n_chk = 0, n_fail = 0;
  logic [15:0] rdq[$];
  logic [47:0] wrq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_map(input int w, input int h, input logic [15:0] ib, input logic [15:0] ob,
                         input bit extra);
    logic [15:0] erd[$];
    logic [47:0] ewr[$];
    logic [15:0] a;
    logic [31:0] mx;
    int ow, oh, n, dk;
    ow = w / 2; oh = h / 2; n = ow * oh;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        mx = 0;
        for (int j = 0; j < 4; j++) begin
          a = 16'(int'(ib) + (2 * r + j / 2) * w + 2 * c + j % 2);
          erd.push_back(a);
          if (mem[a] > mx) mx = mem[a];
        end
        ewr.push_back({16'(int'(ob) + r * ow + c), mx});
      end
    rdq.delete(); wrq.delete();
    @(posedge clk); @(negedge clk);
    in_width = 8'(w); in_height = 8'(h); in_base = ib; out_base = ob; start = 1'b1;
    dk = -1;
    for (int k = 1; k <= 6 * n + 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("busy_after_start", busy, 1);
      if (ifm_rd_en) rdq.push_back(ifm_addr);
      if (ofm_wr_en) wrq.push_back({ofm_addr, ofm_wdata});
      if (done) begin
        dk = k;
        chk("busy_at_done", busy, 0);
        break;
      end
      @(negedge clk);
      start = 1'b0;
      if (extra && k == 4) begin
        start = 1'b1; in_width = 8'd8; in_height = 8'd6; in_base = 16'h40; out_base = 16'h500;
      end
    end
    chk("done_cycle", dk, 6 * n + 2);
    chk("rd_count", rdq.size(), erd.size());
    chk("wr_count", wrq.size(), ewr.size());
    for (int i = 0; i < erd.size() && i < rdq.size(); i++) chk("rd_addr", rdq[i], erd[i]);
    for (int i = 0; i < ewr.size() && i < wrq.size(); i++) chk("wr_addr_data", wrq[i], ewr[i]);
  endtask

  initial begin
    logic [31:0] exp4 [4];
    exp4 = '{32'd5, 32'd7, 32'd13, 32'd15};
    rst = 1'b1; start = 1'b0; in_width = '0; in_height = '0; in_base = '0; out_base = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i);
    #12;
    chk("reset_outputs", {busy, done, ifm_rd_en, pool_en, ofm_wr_en, ifm_addr, ofm_addr, ofm_wdata}, 0);
    @(negedge clk); rst = 1'b0;

    run_map(4, 4, 16'h0, 16'h100, 1'b0);
    for (int i = 0; i < 4 && i < wrq.size(); i++) begin
      chk("4x4_addr", wrq[i][47:32], 16'h100 + 16'(i));
      chk("4x4_data", wrq[i][31:0], exp4[i]);
    end
    run_map(5, 3, 16'h0, 16'h100, 1'b0);
    run_map(1, 4, 16'h0, 16'h100, 1'b0);
    run_map(4, 4, 16'h0, 16'h100, 1'b1);

    // reset during phase 2 of window 1
    @(posedge clk); @(negedge clk);
    in_width = 8'd4; in_height = 8'd4; in_base = '0; out_base = 16'h100; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("pre_rst_running", {busy, pool_en, ifm_rd_en}, 3'b111);
    rst = 1'b1; #1;
    chk("rst_outputs", {busy, done, ifm_rd_en, pool_en, ofm_wr_en, ifm_addr, ofm_addr, ofm_wdata}, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy || ofm_wr_en) chk("no_activity_after_rst", {done, busy, ofm_wr_en}, 0);
    end
    run_map(2, 2, 16'h10, 16'h180, 1'b0);

    mem[16'h200] = 32'hFFFF_FFFF; mem[16'h201] = 0; mem[16'h202] = 1; mem[16'h203] = 2;
    run_map(2, 2, 16'h200, 16'h300, 1'b0);
    if (wrq.size() > 0) chk("max_all_ones", wrq[0][31:0], 32'hFFFF_FFFF);
    else chk("max_all_ones_present", wrq.size(), 1);

    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    for (int t = 0; t < 8; t++)
      run_map($urandom_range(0, 9), $urandom_range(0, 9),
              (t == 3) ? 16'hFFF8 : 16'($urandom), 16'($urandom), t[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
